// File: rtl/ldpc_bf_pkg.sv
// Shared types and sizing helpers for the bit-flipping LDPC decoder control blocks.
package ldpc_bf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } swc_state_e;

  function automatic int calc_nchunk(input int s_length, input int chunk);
    return s_length / chunk;
  endfunction

  function automatic int calc_pcnt_w(input int chunk);
    return $clog2(chunk) + 1;
  endfunction

endpackage

// File: rtl/syndrome_weight_ctrl_if.sv
// Request/result bundle between the decoder sequencer (master) and syndrome_weight_ctrl (slave).
// Handshake: start is a one-cycle request taken only while busy is low; done pulses once per accepted start.
interface syndrome_weight_ctrl_if #(
  parameter int S_LENGTH  = 256,
  parameter int SUM_BITS  = 9,
  parameter int ITER_BITS = 6
);
  logic                 start;
  logic                 clear;
  logic [S_LENGTH-1:0]  s_data;
  logic [ITER_BITS-1:0] max_iter;
  logic                 busy;
  logic                 done;
  logic [SUM_BITS-1:0]  weight;
  logic                 syn_zero;
  logic [ITER_BITS-1:0] iter_cnt;
  logic                 stop;

  modport master (
    output start, clear, s_data, max_iter,
    input  busy, done, weight, syn_zero, iter_cnt, stop
  );

  modport slave (
    input  start, clear, s_data, max_iter,
    output busy, done, weight, syn_zero, iter_cnt, stop
  );
endinterface

// File: rtl/syndrome_weight_ctrl_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice of the syndrome.
module chunk_popcount #(
  parameter int CHUNK = 32,
  parameter int PCW   = 6
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [PCW-1:0]   count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + {{(PCW-1){1'b0}}, data_i[i]};
    end
  end

endmodule

// File: rtl/syndrome_weight_ctrl.sv
// Syndrome Hamming-weight sequencer with iteration counting and sticky decoder stop.
// Optional SYND_PIPE_EN inserts a register between chunk popcount and accumulator (one extra scan cycle).
module syndrome_weight_ctrl
  import ldpc_bf_pkg::*;
#(
  parameter int S_LENGTH  = 256,
  parameter int CHUNK     = 32,
  parameter int SUM_BITS  = 9,
  parameter int ITER_BITS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  syndrome_weight_ctrl_if.slave  bus,
  output swc_state_e             state_o
);

  localparam int NCHUNK = calc_nchunk(S_LENGTH, CHUNK);
  localparam int PCW    = calc_pcnt_w(CHUNK);
  localparam int IDX_W  = $clog2(NCHUNK + 2);
`ifdef SYND_PIPE_EN
  localparam int LAST_IDX = NCHUNK;
`else
  localparam int LAST_IDX = NCHUNK - 1;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

  generate
    if (S_LENGTH % CHUNK != 0) begin : g_len_chk
      $error("S_LENGTH must be a multiple of CHUNK");
    end
    if ((2 ** SUM_BITS) <= S_LENGTH) begin : g_sum_chk
      $error("SUM_BITS too narrow for S_LENGTH");
    end
    if (SUM_BITS < PCW) begin : g_pcw_chk
      $error("SUM_BITS narrower than chunk popcount");
    end
  endgenerate

  swc_state_e           state_q, state_d;
  logic [S_LENGTH-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SUM_BITS-1:0]  acc_q, acc_d;
  logic [ITER_BITS-1:0] max_q, max_d;
  logic [SUM_BITS-1:0]  weight_q, weight_d;
  logic                 syn_zero_q, syn_zero_d;
  logic [ITER_BITS-1:0] iter_q, iter_d;
  logic                 stop_q, stop_d;

  logic [PCW-1:0]       pc_now;
  logic [SUM_BITS-1:0]  add_term;
  logic [SUM_BITS-1:0]  acc_sum;
  logic [ITER_BITS-1:0] iter_inc;

  chunk_popcount #(
    .CHUNK (CHUNK),
    .PCW   (PCW)
  ) u_chunk_popcount (
    .data_i  (shift_q[CHUNK-1:0]),
    .count_o (pc_now)
  );

`ifdef SYND_PIPE_EN
  logic [PCW-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_now;
    end
  end

  // Index 0 has nothing in the pipe register yet; the extra last index drains it.
  assign add_term = (idx_q != '0) ? SUM_BITS'(pc_q) : '0;
`else
  assign add_term = SUM_BITS'(pc_now);
`endif

  assign acc_sum  = acc_q + add_term;
  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + ITER_BITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      weight_q   <= '0;
      syn_zero_q <= 1'b0;
      iter_q     <= '0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      max_q      <= max_d;
      weight_q   <= weight_d;
      syn_zero_q <= syn_zero_d;
      iter_q     <= iter_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    max_d      = max_q;
    weight_d   = weight_q;
    syn_zero_d = syn_zero_q;
    iter_d     = iter_q;
    stop_d     = stop_q;

    unique case (state_q)
      ST_IDLE: begin
        // Clear takes effect before a simultaneous start, so that evaluation counts from zero.
        if (bus.clear) begin
          iter_d = '0;
          stop_d = 1'b0;
        end
        if (bus.start) begin
          state_d = ST_SCAN;
          shift_d = bus.s_data;
          max_d   = bus.max_iter;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> CHUNK;
        idx_d   = idx_q + IDX_W'(1);
        // Results commit here so they are already valid while done is high.
        if (idx_q == LAST) begin
          state_d    = ST_DONE;
          weight_d   = acc_sum;
          syn_zero_d = (acc_sum == '0);
          iter_d     = iter_inc;
          stop_d     = stop_q | (acc_sum == '0) | (iter_inc >= max_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.weight   = weight_q;
  assign bus.syn_zero = syn_zero_q;
  assign bus.iter_cnt = iter_q;
  assign bus.stop     = stop_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_syndrome_weight_ctrl.sv
// Scoreboard bench for syndrome_weight_ctrl: expected results queued at start, compared at done.
module tb_syndrome_weight_ctrl;
  import ldpc_bf_pkg::*;

  localparam int S_LENGTH  = 256;
  localparam int CHUNK     = 32;
  localparam int SUM_BITS  = 9;
  localparam int ITER_BITS = 6;
  localparam int EXP_W     = 2 + ITER_BITS + SUM_BITS;
`ifdef SYND_PIPE_EN
  localparam int EXP_LAT = 10;
`else
  localparam int EXP_LAT = 9;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  syndrome_weight_ctrl_if #(
    .S_LENGTH  (S_LENGTH),
    .SUM_BITS  (SUM_BITS),
    .ITER_BITS (ITER_BITS)
  ) bus ();

  swc_state_e dbg_state;

  syndrome_weight_ctrl #(
    .S_LENGTH  (S_LENGTH),
    .CHUNK     (CHUNK),
    .SUM_BITS  (SUM_BITS),
    .ITER_BITS (ITER_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int m_iter   = 0;
  logic m_stop = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // scoreboard
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("weight",   32'(bus.weight),   32'(e[SUM_BITS-1:0]));
        chk("iter_cnt", 32'(bus.iter_cnt), 32'(e[SUM_BITS +: ITER_BITS]));
        chk("syn_zero", 32'(bus.syn_zero), 32'(e[EXP_W-2]));
        chk("stop",     32'(bus.stop),     32'(e[EXP_W-1]));
      end
    end
  end

  task automatic push_exp(input logic [S_LENGTH-1:0] d, input int mi, input bit with_clear);
    int w;
    w = $countones(d);
    if (with_clear) begin
      m_iter = 0;
      m_stop = 1'b0;
    end
    if (m_iter < (2 ** ITER_BITS) - 1) m_iter++;
    m_stop = m_stop | (w == 0) | (m_iter >= mi);
    exp_q.push_back({m_stop, (w == 0), ITER_BITS'(m_iter), SUM_BITS'(w)});
  endtask

  function automatic logic [S_LENGTH-1:0] rand_syn();
    logic [S_LENGTH-1:0] d;
    for (int k = 0; k < S_LENGTH / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end while (!bus.done && lat < 40);
    if (!bus.done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // driver
  task automatic run_eval(input logic [S_LENGTH-1:0] d, input int mi, input bit with_clear,
                          input string tag);
    int lat;
    push_exp(d, mi, with_clear);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.clear    = with_clear;
    bus.s_data   = d;
    bus.max_iter = ITER_BITS'(mi);
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.clear  = 1'b0;
    bus.s_data = rand_syn();
    wait_done(tag, lat);
    chk({tag, "_latency"}, 32'(lat), 32'(EXP_LAT));
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    m_iter = 0;
    m_stop = 1'b0;
    @(negedge clk);
    chk("clear_iter", 32'(bus.iter_cnt), 32'(m_iter));
    chk("clear_stop", 32'(bus.stop), 32'(m_stop));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},     32'(bus.busy),     32'd0);
    chk({tag, "_done"},     32'(bus.done),     32'd0);
    chk({tag, "_weight"},   32'(bus.weight),   32'd0);
    chk({tag, "_syn_zero"}, 32'(bus.syn_zero), 32'd0);
    chk({tag, "_iter"},     32'(bus.iter_cnt), 32'd0);
    chk({tag, "_stop"},     32'(bus.stop),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [S_LENGTH-1:0] d, d2;
    int lat, dc0;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.clear    = 1'b0;
    bus.s_data   = '0;
    bus.max_iter = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    run_eval('0, 10, 1'b0, "zeros");
    do_clear();
    run_eval('1, 10, 1'b0, "ones");
    d = '0;
    d[S_LENGTH-1] = 1'b1;
    run_eval(d, 10, 1'b0, "msb_only");

    do_clear();
    d = {(S_LENGTH/8){8'h55}};
    for (int i = 0; i < 3; i++) run_eval(d, 3, 1'b0, "alt");
    do_clear();

    // second start while scanning must be dropped
    d  = rand_syn();
    d2 = ~d;
    dc0 = done_cnt;
    push_exp(d, 10, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.s_data = d; bus.max_iter = ITER_BITS'(10);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk); #1;
    bus.start = 1'b1; bus.s_data = d2; bus.max_iter = ITER_BITS'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("ignore_start", lat);
    repeat (12) @(negedge clk);
    chk("ignore_start_done_cnt", 32'(done_cnt - dc0), 32'd1);
    chk("ignore_start_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset in the middle of a scan
    @(posedge clk); #1;
    bus.start = 1'b1; bus.s_data = rand_syn(); bus.max_iter = ITER_BITS'(5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_scan_rst");
    m_iter = 0;
    m_stop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_eval(rand_syn(), 5, 1'b0, "after_rst");

    // zero budget stops on the first done, clear+start together restarts counting
    run_eval(rand_syn(), 0, 1'b1, "max_zero");
    for (int i = 0; i < 6; i++) begin
      run_eval(rand_syn(), $urandom_range(0, 4), ($urandom_range(0, 2) == 0), "rand");
    end
    run_eval(rand_syn(), 8, 1'b1, "clear_with_start");

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
